// File: rtl/pc_if.sv
// Fetch-stage control and status bundle between the pipeline and the PC unit.
interface pc_if #(
  parameter int WIDTH = 32
);
  logic             enable;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_target;
  logic             exc_valid;
  logic [WIDTH-1:0] exc_pc;
  logic             eret;
  logic [WIDTH-1:0] current;
  logic [WIDTH-1:0] pc_plus_step;
  logic             fetch_valid;
  logic [WIDTH-1:0] epc;
  logic             pending_valid;
  logic             misaligned;

  // Pipeline side: drives control, observes the fetch address.
  modport master (
    output enable, redirect_valid, redirect_target, exc_valid, exc_pc, eret,
    input  current, pc_plus_step, fetch_valid, epc, pending_valid, misaligned
  );

  // PC unit side.
  modport slave (
    input  enable, redirect_valid, redirect_target, exc_valid, exc_pc, eret,
    output current, pc_plus_step, fetch_valid, epc, pending_valid, misaligned
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter for the fetch stage: boot hold, prioritised next-PC
// selection, stall handling with a one-entry redirect buffer, and EPC.
module pc_unit #(
  parameter int WIDTH        = 32,
  parameter     RESET_VECTOR = 0,
  parameter     EXC_VECTOR   = 32'h0000_0180,
  parameter     STEP         = 4,
  parameter int BOOT_HOLD    = 2
) (
  input logic pc_clk,
  input logic reset,
  pc_if.slave bus
);

  localparam int CNT_W = (BOOT_HOLD < 2) ? 1 : $clog2(BOOT_HOLD + 1);
  localparam logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] EXC_VEC   = WIDTH'(EXC_VECTOR);
  localparam logic [WIDTH-1:0] STEP_VAL  = WIDTH'(STEP);
  localparam logic [CNT_W-1:0] HOLD_VAL  = CNT_W'(BOOT_HOLD);

  typedef enum logic {BOOT, RUN} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] current_reg, current_next;
  logic [WIDTH-1:0] epc_reg, epc_next;
  logic [WIDTH-1:0] pend_reg, pend_next;
  logic             pend_valid_reg, pend_valid_next;
  logic [WIDTH-1:0] redir_target;

  // eret reuses the redirect path with the saved EPC as its target.
  assign redir_target = bus.eret ? epc_reg : bus.redirect_target;

  // State register; reset restarts the boot hold and drops any buffered redirect.
  always_ff @(posedge pc_clk) begin
    if (reset) begin
      state_reg      <= (BOOT_HOLD == 0) ? RUN : BOOT;
      count_reg      <= HOLD_VAL;
      current_reg    <= RESET_VEC;
      epc_reg        <= '0;
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      current_reg    <= current_next;
      epc_reg        <= epc_next;
      pend_reg       <= pend_next;
      pend_valid_reg <= pend_valid_next;
    end
  end

  // Next-state and next-PC selection: exception, redirect/eret, pending, step.
  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    current_next    = current_reg;
    epc_next        = epc_reg;
    pend_next       = pend_reg;
    pend_valid_next = pend_valid_reg;
    case (state_reg)
      BOOT: begin
        // All pipeline inputs are ignored until the hold expires.
        if (count_reg <= CNT_W'(1)) begin
          state_next = RUN;
        end
        if (count_reg != '0) begin
          count_next = count_reg - CNT_W'(1);
        end
      end
      RUN: begin
        if (bus.exc_valid) begin
          // Exceptions override stalls and any buffered redirect.
          current_next    = EXC_VEC;
          epc_next        = bus.exc_pc;
          pend_valid_next = 1'b0;
        end else if (bus.eret || bus.redirect_valid) begin
          if (bus.enable) begin
            current_next    = redir_target;
            pend_valid_next = 1'b0;
          end else begin
            // Stalled: remember the newest redirect until the pipeline moves.
            pend_next       = redir_target;
            pend_valid_next = 1'b1;
          end
        end else if (bus.enable) begin
          if (pend_valid_reg) begin
            current_next    = pend_reg;
            pend_valid_next = 1'b0;
          end else begin
            current_next = current_reg + STEP_VAL;
          end
        end
      end
      default: state_next = BOOT;
    endcase
  end

  assign bus.current       = current_reg;
  assign bus.pc_plus_step  = current_reg + STEP_VAL;
  assign bus.fetch_valid   = (state_reg == RUN);
  assign bus.epc           = epc_reg;
  assign bus.pending_valid = pend_valid_reg;
  assign bus.misaligned    = bus.fetch_valid & (|current_reg[1:0]);

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed table of the key scenarios, then random traffic
// compared against a queue-based behavioural model.
module tb_pc_unit;

  localparam int WIDTH = 32;
  localparam int HOLD  = 2;

  logic pc_clk = 1'b0;
  logic reset  = 1'b1;
  always #5 pc_clk = ~pc_clk;

  pc_if #(.WIDTH(WIDTH)) bus ();

  pc_unit #(
    .WIDTH(WIDTH), .RESET_VECTOR(0), .EXC_VECTOR(32'h0000_0180),
    .STEP(4), .BOOT_HOLD(HOLD)
  ) dut (
    .pc_clk(pc_clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rst, en, rv, exc, eret;
    logic [31:0] rt, ep;
    logic [31:0] e_cur, e_epc;
    bit          e_pend, e_fv;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: boot countdown as an integer, buffered redirects as a queue.
  logic [31:0] m_cur = 0, m_epc = 0;
  logic [31:0] m_pend[$];
  int          m_boot = HOLD;
  bit          m_run  = 0;

  function automatic vec_t mk(bit rst, bit en, bit rv, logic [31:0] rt, bit exc,
                              logic [31:0] ep, bit eret, logic [31:0] ec,
                              logic [31:0] eepc, bit epend, bit efv);
    vec_t v;
    v.rst = rst; v.en = en; v.rv = rv; v.rt = rt; v.exc = exc; v.ep = ep; v.eret = eret;
    v.e_cur = ec; v.e_epc = eepc; v.e_pend = epend; v.e_fv = efv;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input vec_t v);
    logic [31:0] t;
    if (v.rst) begin
      m_cur = 0; m_epc = 0; m_pend.delete();
      m_boot = HOLD; m_run = (HOLD == 0);
    end else if (!m_run) begin
      m_boot--;
      if (m_boot <= 0) m_run = 1;
    end else if (v.exc) begin
      m_cur = 32'h180; m_epc = v.ep; m_pend.delete();
    end else if (v.eret || v.rv) begin
      t = v.eret ? m_epc : v.rt;
      if (v.en) begin
        m_cur = t; m_pend.delete();
      end else begin
        m_pend.push_back(t);
      end
    end else if (v.en && m_pend.size() > 0) begin
      m_cur = m_pend[$]; m_pend.delete();
    end else if (v.en) begin
      m_cur = m_cur + 32'd4;
    end
  endtask

  // Apply one cycle of inputs and sample just after the edge.
  task automatic apply(input vec_t v);
    reset              = v.rst;
    bus.enable         = v.en;
    bus.redirect_valid = v.rv;
    bus.redirect_target= v.rt;
    bus.exc_valid      = v.exc;
    bus.exc_pc         = v.ep;
    bus.eret           = v.eret;
    @(posedge pc_clk);
    #1;
    model_edge(v);
  endtask

  initial begin
    vec_t v;
    bus.enable = 0; bus.redirect_valid = 0; bus.redirect_target = 0;
    bus.exc_valid = 0; bus.exc_pc = 0; bus.eret = 0;
    #2;

    //        rst en rv rt            exc ep    eret  cur           epc    pend fv
    vecs.push_back(mk(1, 1, 0, 0,            0, 0,    0, 32'h0,        0,     0, 0));
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,    0, 32'h0,        0,     0, 0));
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,    0, 32'h0,        0,     0, 1));
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,    0, 32'h4,        0,     0, 1));
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,    0, 32'h8,        0,     0, 1));
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,    0, 32'hC,        0,     0, 1));
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,    0, 32'h10,       0,     0, 1));
    vecs.push_back(mk(0, 1, 1, 32'h200,      0, 0,    0, 32'h200,      0,     0, 1));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,    0, 32'h200,      0,     0, 1));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,    0, 32'h200,      0,     0, 1));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,    0, 32'h200,      0,     0, 1));
    vecs.push_back(mk(0, 0, 1, 32'h40,       0, 0,    0, 32'h200,      0,     1, 1));
    vecs.push_back(mk(0, 0, 1, 32'h80,       0, 0,    0, 32'h200,      0,     1, 1));
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,    0, 32'h80,       0,     0, 1));
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,    0, 32'h84,       0,     0, 1));
    vecs.push_back(mk(0, 0, 0, 0,            1, 32'h1C, 0, 32'h180,    32'h1C, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,    0, 32'h180,      32'h1C, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,    1, 32'h1C,       32'h1C, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,    0, 32'h20,       32'h1C, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0,            1, 32'h24, 1, 32'h180,    32'h24, 0, 1));
    vecs.push_back(mk(0, 1, 1, 32'hFFFF_FFFC,0, 0,    0, 32'hFFFF_FFFC,32'h24, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,    0, 32'h0,        32'h24, 0, 1));
    vecs.push_back(mk(0, 1, 1, 32'h102,      0, 0,    0, 32'h102,      32'h24, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,    0, 32'h106,      32'h24, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0,            1, 32'h1C, 0, 32'h180,    32'h1C, 0, 1));
    vecs.push_back(mk(0, 0, 1, 32'h300,      0, 0,    0, 32'h180,      32'h1C, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0,            1, 32'h50, 0, 32'h180,    32'h50, 0, 1));
    vecs.push_back(mk(0, 0, 1, 32'h310,      0, 0,    0, 32'h180,      32'h50, 1, 1));
    vecs.push_back(mk(0, 1, 1, 32'h320,      0, 0,    0, 32'h320,      32'h50, 0, 1));
    vecs.push_back(mk(0, 0, 1, 32'h330,      0, 0,    0, 32'h320,      32'h50, 1, 1));
    vecs.push_back(mk(1, 1, 1, 32'h400,      0, 0,    0, 32'h0,        0,     0, 0));
    vecs.push_back(mk(0, 1, 0, 0,            1, 32'h77, 0, 32'h0,      0,     0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h500,      0, 0,    0, 32'h0,        0,     0, 1));
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,    0, 32'h4,        0,     0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      apply(v);
      check($sformatf("vec%0d current", i), bus.current, v.e_cur);
      check($sformatf("vec%0d epc", i), bus.epc, v.e_epc);
      check($sformatf("vec%0d pending_valid", i), 32'(bus.pending_valid), 32'(v.e_pend));
      check($sformatf("vec%0d fetch_valid", i), 32'(bus.fetch_valid), 32'(v.e_fv));
      check($sformatf("vec%0d pc_plus_step", i), bus.pc_plus_step, v.e_cur + 32'd4);
      check($sformatf("vec%0d misaligned", i), 32'(bus.misaligned),
            32'(v.e_fv && (v.e_cur % 4 != 0)));
      $display("vec %0d: current=0x%08h epc=0x%08h pend=%0b fv=%0b",
               i, bus.current, bus.epc, bus.pending_valid, bus.fetch_valid);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] exp_cur;
      bit          exp_fv;
      v.rst  = ($urandom_range(0, 59) == 0);
      v.en   = ($urandom_range(0, 9) < 7);
      v.rv   = ($urandom_range(0, 4) == 0);
      v.rt   = $urandom & 32'hFFFF_FFFE;
      if ($urandom_range(0, 3) == 0) v.rt = v.rt | 32'h1;
      v.exc  = ($urandom_range(0, 19) == 0);
      v.ep   = $urandom;
      v.eret = ($urandom_range(0, 19) == 0);
      apply(v);
      exp_cur = m_cur;
      exp_fv  = m_run;
      check("rand current", bus.current, exp_cur);
      check("rand epc", bus.epc, m_epc);
      check("rand pending_valid", 32'(bus.pending_valid), 32'(m_pend.size() > 0));
      check("rand fetch_valid", 32'(bus.fetch_valid), 32'(exp_fv));
      check("rand pc_plus_step", bus.pc_plus_step, exp_cur + 32'd4);
      check("rand misaligned", 32'(bus.misaligned), 32'(exp_fv && (exp_cur % 4 != 0)));
      $display("rand %0d: rst=%0b en=%0b rv=%0b exc=%0b eret=%0b current=0x%08h",
               i, v.rst, v.en, v.rv, v.exc, v.eret, bus.current);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the pipelined MIPS fetch stage, generalising the plain stall-able PC register. Holds the fetch address, selects next PC by priority (exception, return-from-exception, branch/jump redirect, sequential step), and honours pipeline stalls. Redirects that arrive during a stall are buffered rather than lost. Also provides a post-reset boot hold and an exception PC (EPC) register.

## Interface
- WIDTH, 32: address width in bits; must be ≥ 2.
- RESET_VECTOR, 0: value of `current` after reset.
- EXC_VECTOR, 32'h0000_0180: exception handler address, truncated to WIDTH.
- STEP, 4: sequential increment.
- BOOT_HOLD, 2: number of cycles after reset before fetch starts; 0 is legal.

Ports:
- pc_clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = advance; 0 = stall (hold `current`).
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  WIDTH  target address for the redirect.
- exc_valid  in  1  exception raised this cycle.
- exc_pc  in  WIDTH  address of the faulting instruction; captured into `epc`.
- eret  in  1  return from exception; behaves as a redirect to `epc`.
- current  out  WIDTH  registered fetch address.
- pc_plus_step  out  WIDTH  combinational `current + STEP`, modulo 2^WIDTH.
- fetch_valid  out  1  registered; 1 only in RUN.
- epc  out  WIDTH  registered exception PC.
- pending_valid  out  1  registered; a buffered redirect is waiting.
- misaligned  out  1  combinational: `fetch_valid & |current[1:0]`.

## Operation
- **FSM states:**
  - BOOT: a down-counter sized to hold BOOT_HOLD.
  - RUN.
- **Reset (dominates all other inputs):**
  - current = RESET_VECTOR, epc = 0, pending_valid = 0, pending target = 0.
  - Next state is BOOT with count = BOOT_HOLD; if BOOT_HOLD = 0, next state is RUN.
  - Reset asserted mid-operation discards any pending redirect and any in-flight exception.
- **BOOT:**
  - `current` holds; fetch_valid = 0.
  - enable, redirect_valid, exc_valid and eret are ignored, and nothing is buffered.
  - The counter decrements each cycle. Transition to RUN on the edge where count = 1.
  - Net effect: fetch_valid rises exactly BOOT_HOLD cycles after the reset-release edge.
- **RUN, per-edge priority (highest first):**
  1. exc_valid: current ← EXC_VECTOR, epc ← exc_pc, pending cleared. Takes effect even when enable = 0; exceptions override stalls.
  2. eret, or redirect_valid (eret wins if both asserted). Target is `epc` for eret, `redirect_target` otherwise.
     - enable = 1: current ← target; any older pending redirect is discarded.
     - enable = 0: current holds; pending ← target, pending_valid ← 1. A newer redirect overwrites an older pending one.
  3. enable = 1 with pending_valid = 1: current ← pending target, pending_valid ← 0.
  4. enable = 1: current ← current + STEP, wrapping modulo 2^WIDTH.
  5. enable = 0: hold everything.
- **Arithmetic:** all addresses are WIDTH bits, unsigned, and wrap silently. No overflow flag.
- **Exception and eret together:** exc_valid wins. epc is updated and eret is dropped.
- **Misaligned addresses:** targets are loaded unmodified; `misaligned` only flags them. The pipeline is responsible for raising the exception.

## Timing
- Latency is one cycle from any input to `current`, `epc` and `pending_valid`.
- `pc_plus_step` and `misaligned` are combinational from `current` and have zero latency.
- A redirect presented during a stall is buffered. It appears on `current` one edge after the first cycle with enable = 1.
- There is no handshake; every input is sampled on every RUN edge.

## Test plan
- **Reset and boot hold, sequential fetch.** BOOT_HOLD = 2, reset high for 1 cycle, enable = 1.
  - Required: fetch_valid = 0 for 2 edges and current = 0 throughout.
  - Then fetch_valid = 1 and current steps 0 → 4 → 8.
- **Stall and redirect.**
  - At current = 0x10 with enable = 1 and redirect 0x200: next current = 0x200.
  - Stall for 3 cycles: current stays 0x200.
  - pc_plus_step = 0x204 throughout the stall.
- **Redirect during stall is buffered, newest wins.** While enable = 0, present redirect 0x40, then redirect 0x80.
  - Required: pending_valid = 1 and current holds.
  - On the first enable = 1 edge: current = 0x80 and pending_valid = 0.
- **Exception during stall, then return.** enable = 0, exc_valid with exc_pc = 0x1C.
  - Required: current = 0x180 and epc = 0x1C on the next edge.
  - A later eret with enable = 1 gives current = 0x1C.
  - Also check exc_valid and eret on the same edge: the exception wins.
- **Wrap and misaligned flag.**
  - current = 0xFFFF_FFFC, step: result is 0x0000_0000.
  - redirect 0x102: misaligned = 1 while current = 0x102.
- **Reset mid-operation.** Assert reset with pending_valid = 1 and epc = 0x1C.
  - Required: current = RESET_VECTOR, pending_valid = 0, epc = 0, fetch_valid = 0.
  - The boot hold then restarts.
